// File: rtl/water_level_ctrl_if.sv
// Bus between the bakery tank level switches / valves and the level controller.
// The tank-side driver (bench or plant) uses master, the controller uses slave.
interface water_level_ctrl_if;
    logic       en;
    logic       fill_req;
    logic       drain_req;
    logic       fault_clr;
    logic       Y_water_base;
    logic       Y_water_middle;
    logic       Y_water_top;
    logic       X_water;
    logic       X_drain;
    logic       ready;
    logic       busy;
    logic       fault;
    logic [1:0] fault_code;

    modport master (
        output en, fill_req, drain_req, fault_clr,
        output Y_water_base, Y_water_middle, Y_water_top,
        input  X_water, X_drain, ready, busy, fault, fault_code
    );

    modport slave (
        input  en, fill_req, drain_req, fault_clr,
        input  Y_water_base, Y_water_middle, Y_water_top,
        output X_water, X_drain, ready, busy, fault, fault_code
    );
endinterface

// File: rtl/water_level_ctrl.sv
// Closed-loop fill/hold/drain controller for the bakery water tank,
// with fill/drain timeouts and a latched sensor-consistency fault.
module water_level_ctrl #(
    parameter int FILL_TIMEOUT  = 64,
    parameter int DRAIN_TIMEOUT = 64,
    parameter int DRAIN_EXTRA   = 4,
    parameter int CNT_W         = 8
) (
    input  logic              clk,
    input  logic              rst,
    water_level_ctrl_if.slave bus
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FILL  = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    localparam logic [CNT_W-1:0] FT = CNT_W'(FILL_TIMEOUT);
    localparam logic [CNT_W-1:0] DT = CNT_W'(DRAIN_TIMEOUT);
    localparam logic [CNT_W-1:0] DE = CNT_W'(DRAIN_EXTRA);

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic             tail, tail_n;
    logic [1:0]       code, code_n;
    logic             x_water_q, x_drain_q;
    logic             ready_q, busy_q, fault_q;
    logic             base, mid, top, bad;

    assign base = bus.Y_water_base;
    assign mid  = bus.Y_water_middle;
    assign top  = bus.Y_water_top;
    assign bad  = (top & ~mid) | (mid & ~base);

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_comb begin
        state_n = state;
        cnt_n   = cnt_inc;
        tail_n  = tail;
        code_n  = code;
        if (state != S_FAULT && bad) begin
            state_n = S_FAULT;
            code_n  = 2'd3;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (bus.drain_req)
                        state_n = S_DRAIN;
                    else if (bus.fill_req)
                        state_n = top ? S_HOLD : S_FILL;
                end
                S_FILL: begin
                    if (top) begin
                        state_n = S_HOLD;
                    end else if (bus.drain_req) begin
                        state_n = S_DRAIN;
                    end else if (cnt_inc >= FT) begin
                        state_n = S_FAULT;
                        code_n  = 2'd1;
                    end
                end
                S_HOLD: begin
                    if (!mid)
                        state_n = S_FILL;
                    else if (bus.drain_req)
                        state_n = S_DRAIN;
                end
                S_DRAIN: begin
                    // tail: base has dropped, count the extra open ticks
                    if (tail) begin
                        if (cnt_inc >= DE)
                            state_n = S_IDLE;
                    end else if (!base) begin
                        tail_n = 1'b1;
                        cnt_n  = '0;
                    end else if (cnt_inc >= DT) begin
                        state_n = S_FAULT;
                        code_n  = 2'd2;
                    end
                end
                S_FAULT: begin
                    if (bus.fault_clr) begin
                        state_n = S_IDLE;
                        code_n  = 2'd0;
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
        if (state_n != state) begin
            cnt_n  = '0;
            tail_n = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            tail      <= 1'b0;
            code      <= 2'd0;
            x_water_q <= 1'b0;
            x_drain_q <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            fault_q   <= 1'b0;
        end else if (bus.en) begin
            state     <= state_n;
            cnt       <= cnt_n;
            tail      <= tail_n;
            code      <= code_n;
            x_water_q <= (state_n == S_FILL);
            x_drain_q <= (state_n == S_DRAIN);
            ready_q   <= (state_n == S_HOLD);
            busy_q    <= (state_n == S_FILL) ||
                         (state_n == S_DRAIN);
            fault_q   <= (state_n == S_FAULT);
        end
    end

    assign bus.X_water    = x_water_q;
    assign bus.X_drain    = x_drain_q;
    assign bus.ready      = ready_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;
    assign bus.fault_code = code;
endmodule

// File: tb/tb_water_level_ctrl.sv
// Bench for water_level_ctrl: directed scenarios with a tank plant,
// then randomized traffic checked every cycle against a mode-level model.
module tb_water_level_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    water_level_ctrl_if bus ();

    water_level_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t",
                     name, act, exp, $time);
        end
    endtask

    // model: mode 0 idle, 1 fill, 2 hold, 3 drain, 4 fault
    int m_mode = 0;
    int m_elapsed = 0;
    int m_left = -1;
    int m_code = 0;

    task automatic m_go(int mode);
        m_mode    = mode;
        m_elapsed = 0;
        m_left    = -1;
    endtask

    task automatic m_step(logic fr, logic dr, logic clr,
                          logic b, logic m, logic t);
        if (m_mode != 4 && ((t && !m) || (m && !b))) begin
            m_go(4);
            m_code = 3;
        end else if (m_mode == 0) begin
            if (dr) m_go(3);
            else if (fr) m_go(t ? 2 : 1);
        end else if (m_mode == 1) begin
            if (t) m_go(2);
            else if (dr) m_go(3);
            else begin
                m_elapsed++;
                if (m_elapsed >= 64) begin
                    m_go(4);
                    m_code = 1;
                end
            end
        end else if (m_mode == 2) begin
            if (!m) m_go(1);
            else if (dr) m_go(3);
        end else if (m_mode == 3) begin
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_go(0);
            end else if (!b) begin
                m_left = 4;
            end else begin
                m_elapsed++;
                if (m_elapsed >= 64) begin
                    m_go(4);
                    m_code = 2;
                end
            end
        end else if (clr) begin
            m_go(0);
            m_code = 0;
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_go(0);
            m_code = 0;
        end else if (bus.en) begin
            m_step(bus.fill_req, bus.drain_req, bus.fault_clr,
                   bus.Y_water_base, bus.Y_water_middle,
                   bus.Y_water_top);
        end
        #1;
        chk("x_water", 8'(bus.X_water), 8'(m_mode == 1));
        chk("x_drain", 8'(bus.X_drain), 8'(m_mode == 3));
        chk("ready", 8'(bus.ready), 8'(m_mode == 2));
        chk("busy", 8'(bus.busy), 8'(m_mode == 1 || m_mode == 3));
        chk("fault", 8'(bus.fault), 8'(m_mode == 4));
        chk("code", 8'(bus.fault_code), 8'(m_code));
    end

    int  lvl = 0;
    logic plant_on = 1'b0;

    task automatic set_sens(logic b, logic m, logic t);
        bus.Y_water_base   = b;
        bus.Y_water_middle = m;
        bus.Y_water_top    = t;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        if (plant_on && bus.en) begin
            lvl = lvl + int'(bus.X_water) - int'(bus.X_drain);
            if (lvl < 0) lvl = 0;
            if (lvl > 40) lvl = 40;
        end
        if (plant_on)
            set_sens(lvl >= 3, lvl >= 20, lvl >= 34);
    endtask

    int n;

    initial begin
        bus.en        = 1'b1;
        bus.fill_req  = 1'b0;
        bus.drain_req = 1'b0;
        bus.fault_clr = 1'b0;
        set_sens(1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outs", {3'b0, bus.X_water, bus.X_drain,
            bus.ready, bus.busy, bus.fault}, 8'd0);
        chk("rst_code", 8'(bus.fault_code), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // cold fill with the plant attached
        plant_on = 1'b1;
        lvl = 0;
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        n = 0;
        while (bus.X_water && n < 200) begin
            n++;
            step();
        end
        chk("fill_ticks", 8'(n), 8'd34);
        chk("fill_ready", 8'(bus.ready), 8'd1);

        // hysteresis refill
        plant_on = 1'b0;
        set_sens(1'b1, 1'b0, 1'b0);
        step();
        chk("hyst_refill", 8'(bus.X_water), 8'd1);
        set_sens(1'b1, 1'b1, 1'b1);
        step();
        chk("hyst_hold", 8'(bus.ready), 8'd1);
        chk("hyst_valve", 8'(bus.X_water), 8'd0);

        // drain from hold, fill_req ignored meanwhile
        plant_on = 1'b1;
        lvl = 34;
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        bus.fill_req  = 1'b1;
        n = 0;
        while (bus.X_drain && n < 200) begin
            n++;
            if (n == 5) bus.fill_req = 1'b0;
            step();
        end
        chk("drain_ticks", 8'(n), 8'd36);
        chk("drain_idle", 8'(bus.busy | bus.ready), 8'd0);

        // fill timeout with a 10-cycle en gap
        plant_on = 1'b0;
        set_sens(1'b0, 1'b0, 1'b0);
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        n = 0;
        while (bus.X_water && n < 200) begin
            n++;
            if (n == 20) begin
                bus.en = 1'b0;
                repeat (10) begin
                    step();
                    chk("gate_valve", 8'(bus.X_water), 8'd1);
                end
                bus.en = 1'b1;
            end
            step();
        end
        chk("ftmo_ticks", 8'(n), 8'd64);
        chk("ftmo_fault", 8'(bus.fault), 8'd1);
        chk("ftmo_code", 8'(bus.fault_code), 8'd1);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;
        chk("clr_fault", 8'(bus.fault), 8'd0);
        chk("clr_code", 8'(bus.fault_code), 8'd0);

        // drain timeout, base stuck high
        set_sens(1'b1, 1'b0, 1'b0);
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        n = 0;
        while (bus.X_drain && n < 200) begin
            n++;
            step();
        end
        chk("dtmo_ticks", 8'(n), 8'd64);
        chk("dtmo_code", 8'(bus.fault_code), 8'd2);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;

        // sensor inconsistency during fill
        set_sens(1'b0, 1'b0, 1'b0);
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        repeat (3) step();
        set_sens(1'b1, 1'b0, 1'b1);
        step();
        chk("sens_code", 8'(bus.fault_code), 8'd3);
        chk("sens_valve", 8'(bus.X_water), 8'd0);
        set_sens(1'b0, 1'b0, 1'b0);
        bus.fault_clr = 1'b1;
        step();
        bus.fault_clr = 1'b0;

        // async reset mid-drain
        set_sens(1'b1, 1'b1, 1'b1);
        bus.fill_req = 1'b1;
        step();
        bus.fill_req = 1'b0;
        chk("top_hold", 8'(bus.ready), 8'd1);
        bus.drain_req = 1'b1;
        step();
        bus.drain_req = 1'b0;
        repeat (2) step();
        chk("pre_rst", 8'(bus.X_drain), 8'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("async_drain", 8'(bus.X_drain), 8'd0);
        chk("async_busy", 8'(bus.busy), 8'd0);
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic with a leaky plant and sensor glitches
        plant_on = 1'b1;
        lvl = $urandom_range(0, 40);
        for (int i = 0; i < 3000; i++) begin
            bus.en        = ($urandom_range(0, 3) != 0);
            bus.fill_req  = ($urandom_range(0, 7) == 0);
            bus.drain_req = ($urandom_range(0, 19) == 0);
            bus.fault_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0 && lvl > 0) lvl--;
            step();
            if ($urandom_range(0, 49) == 0) begin
                set_sens($urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1,
                         $urandom_range(0, 1) == 1);
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
